// File: rtl/addr_map_cfg_ctrl_pkg.sv
// Shared types and helpers for the address-map configuration controller.
package addr_map_cfg_ctrl_pkg;

    // Width needed to index num_idx items; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
    endfunction

    typedef logic [31:0] cfg_addr_t;

    // Same layout as the decoder rule: target index plus an address window.
    typedef struct packed {
        logic [31:0] idx;
        cfg_addr_t   start_addr;
        cfg_addr_t   end_addr;
    } cfg_rule_t;

    typedef enum logic [1:0] {
        UNCFG  = 2'd0,
        IDLE   = 2'd1,
        DRAIN  = 2'd2,
        SETTLE = 2'd3
    } state_e;

endpackage

// File: rtl/addr_map_cfg_ctrl_if.sv
// Rule-write and commit handshakes between a configuring master and the controller.
interface addr_map_cfg_ctrl_if #(
    parameter type         rule_t       = addr_map_cfg_ctrl_pkg::cfg_rule_t,
    parameter int unsigned RuleSelWidth = 2,
    parameter int unsigned IdxWidth     = 2
) ();
    logic                    wr_valid_i;
    logic                    wr_ready_o;
    logic [RuleSelWidth-1:0] wr_sel_i;
    rule_t                   wr_rule_i;
    logic                    commit_valid_i;
    logic                    commit_ready_o;
    logic                    dflt_en_i;
    logic [IdxWidth-1:0]     dflt_idx_i;
    logic                    err_o;

    modport master (
        output wr_valid_i, wr_sel_i, wr_rule_i, commit_valid_i, dflt_en_i, dflt_idx_i,
        input  wr_ready_o, commit_ready_o, err_o
    );

    modport slave (
        input  wr_valid_i, wr_sel_i, wr_rule_i, commit_valid_i, dflt_en_i, dflt_idx_i,
        output wr_ready_o, commit_ready_o, err_o
    );
endinterface

// File: rtl/addr_map_cfg_ctrl_counter.sv
// Loadable down-counter used to time the post-swap settle window.
module addr_map_cfg_ctrl_counter #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] d_i,
    input  logic             en_i,
    output logic [Width-1:0] q_o
);
    logic [Width-1:0] r_cnt;

    // Load has priority over decrement so a fresh swap always restarts the window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= d_i;
        end else if (en_i) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign q_o = r_cnt;
endmodule

// File: rtl/addr_map_cfg_ctrl.sv
// Runtime configuration controller: shadow rule table, drain-then-swap commit,
// and a settle window so the decoder never sees a half-written map.
module addr_map_cfg_ctrl
    import addr_map_cfg_ctrl_pkg::*;
#(
    parameter int unsigned NoRules      = 4,
    parameter int unsigned NoIndices    = 4,
    parameter type         addr_t       = addr_map_cfg_ctrl_pkg::cfg_addr_t,
    parameter type         rule_t       = addr_map_cfg_ctrl_pkg::cfg_rule_t,
    parameter int unsigned SettleCycles = 1,
    parameter int unsigned IdxWidth     = idx_width(NoIndices),
    parameter int unsigned RuleSelWidth = idx_width(NoRules)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    addr_map_cfg_ctrl_if.slave                cfg,
    input  logic                              busy_i,
    output logic [NoRules*$bits(rule_t)-1:0]  addr_map_o,
    output logic                              en_default_idx_o,
    output logic [IdxWidth-1:0]               default_idx_o,
    output logic                              config_ongoing_o,
    output logic                              dirty_o
);
    localparam int unsigned RULE_W = $bits(rule_t);
    localparam int unsigned ADDR_W = $bits(addr_t);
    localparam int unsigned CNT_W  = idx_width(SettleCycles + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD =
        (SettleCycles > 0) ? CNT_W'(SettleCycles - 1) : '0;
    // One extra bit so NoRules itself is representable for the range check.
    localparam logic [RuleSelWidth:0] NO_RULES_EXT = (RuleSelWidth + 1)'(NoRules);

    state_e              r_state;
    logic                r_ongoing;
    logic                r_cfg_ready;
    logic                r_dirty;
    logic                r_err;
    logic                r_shadow_en;
    logic [IdxWidth-1:0] r_shadow_idx;
    logic                r_active_en;
    logic [IdxWidth-1:0] r_active_idx;
    rule_t               r_shadow [NoRules];
    rule_t               r_active [NoRules];

    logic                w_wr_fire;
    logic                w_wr_ok;
    logic                w_sel_ok;
    logic                w_idx_ok;
    logic                w_commit_fire;
    logic                w_swap;
    logic                w_cnt_en;
    logic                w_cnt_zero;
    logic [CNT_W-1:0]    w_cnt_q;

    assign w_wr_fire     = cfg.wr_valid_i & r_cfg_ready;
    assign w_commit_fire = cfg.commit_valid_i & r_cfg_ready;
    assign w_sel_ok      = ({1'b0, cfg.wr_sel_i} < NO_RULES_EXT);
    assign w_idx_ok      = (cfg.wr_rule_i.idx < 32'(NoIndices));
    assign w_wr_ok       = w_wr_fire & w_sel_ok & w_idx_ok;
    // The swap happens on the first DRAIN cycle where downstream reports idle.
    assign w_swap        = (r_state == DRAIN) & ~busy_i;
    assign w_cnt_en      = (r_state == SETTLE) & ~w_cnt_zero;
    assign w_cnt_zero    = (w_cnt_q == '0);

    addr_map_cfg_ctrl_counter #(
        .Width (CNT_W)
    ) u_settle_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (w_swap),
        .d_i    (SETTLE_LOAD),
        .en_i   (w_cnt_en),
        .q_o    (w_cnt_q)
    );

    // Control FSM; ongoing and ready are registered decodes of the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= UNCFG;
            r_ongoing   <= 1'b1;
            r_cfg_ready <= 1'b1;
        end else begin
            case (r_state)
                UNCFG, IDLE: begin
                    if (w_commit_fire) begin
                        r_state     <= DRAIN;
                        r_ongoing   <= 1'b1;
                        r_cfg_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!busy_i) begin
                        if (SettleCycles == 0) begin
                            r_state     <= IDLE;
                            r_ongoing   <= 1'b0;
                            r_cfg_ready <= 1'b1;
                        end else begin
                            r_state <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (w_cnt_zero) begin
                        r_state     <= IDLE;
                        r_ongoing   <= 1'b0;
                        r_cfg_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= UNCFG;
                    r_ongoing   <= 1'b1;
                    r_cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    // Dirty tracking, reject pulse, default-index shadow and active copies.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dirty      <= 1'b0;
            r_err        <= 1'b0;
            r_shadow_en  <= 1'b0;
            r_shadow_idx <= '0;
            r_active_en  <= 1'b0;
            r_active_idx <= '0;
        end else begin
            r_err <= w_wr_fire & ~w_wr_ok;
            if (w_commit_fire) begin
                r_shadow_en  <= cfg.dflt_en_i;
                r_shadow_idx <= cfg.dflt_idx_i;
            end
            if (w_swap) begin
                r_active_en  <= r_shadow_en;
                r_active_idx <= r_shadow_idx;
                r_dirty      <= 1'b0;
            end else if (w_wr_ok) begin
                r_dirty <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NoRules; gi++) begin : g_slot
        // Shadow slot takes an accepted write addressed to it; last write wins.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_shadow[gi] <= '0;
            end else if (w_wr_ok && (cfg.wr_sel_i == RuleSelWidth'(gi))) begin
                r_shadow[gi] <= cfg.wr_rule_i;
            end
        end

        // Active slot changes only at the swap edge, all slots together.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_active[gi] <= '0;
            end else if (w_swap) begin
                r_active[gi] <= r_shadow[gi];
            end
        end

        assign addr_map_o[gi*RULE_W +: RULE_W] = r_active[gi];
    end

    assign cfg.wr_ready_o     = r_cfg_ready;
    assign cfg.commit_ready_o = r_cfg_ready;
    assign cfg.err_o          = r_err;
    assign en_default_idx_o   = r_active_en;
    assign default_idx_o      = r_active_idx;
    assign config_ongoing_o   = r_ongoing;
    assign dirty_o            = r_dirty;

`ifndef SYNTHESIS
    a_addr_field: assert property (@(posedge clk_i)
        $bits(cfg.wr_rule_i.start_addr) == ADDR_W);

    a_idle_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_state == IDLE && !w_wr_fire && !w_commit_fire) |=>
        ($stable(addr_map_o) && $stable(en_default_idx_o) &&
         $stable(default_idx_o) && !config_ongoing_o));

    a_ongoing_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_state inside {DRAIN, SETTLE}) |-> config_ongoing_o);
`endif
endmodule

// File: tb/tb_addr_map_cfg_ctrl.sv
// Bench for addr_map_cfg_ctrl: table-driven rule writes plus hand-built commit sequences.
module tb_addr_map_cfg_ctrl;
    import addr_map_cfg_ctrl_pkg::*;

    localparam int NR  = 3;           // NoRules=3 so sel=NoRules fits in the select field
    localparam int NI  = 4;
    localparam int RSW = 2;
    localparam int IW  = 2;
    localparam int RW  = $bits(cfg_rule_t);
    localparam int MW  = NR * RW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy0 = 1'b0;
    logic busy1 = 1'b0;
    always #5 clk = ~clk;

    addr_map_cfg_ctrl_if #(.rule_t(cfg_rule_t), .RuleSelWidth(RSW), .IdxWidth(IW)) cfg0 ();
    addr_map_cfg_ctrl_if #(.rule_t(cfg_rule_t), .RuleSelWidth(RSW), .IdxWidth(IW)) cfg1 ();

    logic [MW-1:0] map0, map1;
    logic          den0, den1, ong0, ong1, dirty0, dirty1;
    logic [IW-1:0] didx0, didx1;

    addr_map_cfg_ctrl #(.NoRules(NR), .NoIndices(NI), .SettleCycles(1)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .cfg(cfg0), .busy_i(busy0),
        .addr_map_o(map0), .en_default_idx_o(den0), .default_idx_o(didx0),
        .config_ongoing_o(ong0), .dirty_o(dirty0)
    );

    addr_map_cfg_ctrl #(.NoRules(NR), .NoIndices(NI), .SettleCycles(0)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .cfg(cfg1), .busy_i(busy1),
        .addr_map_o(map1), .en_default_idx_o(den1), .default_idx_o(didx1),
        .config_ongoing_o(ong1), .dirty_o(dirty1)
    );

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] idx;
        logic [31:0] st;
        logic [31:0] en;
        logic        exp_err;
    } wr_vec_t;

    typedef struct packed { logic err; logic dirty; } wr_exp_t;
    typedef struct packed { logic [MW-1:0] map; logic en; logic [IW-1:0] idx; } cfg_exp_t;

    wr_vec_t  vecs [6];
    wr_exp_t  wr_q [$];
    cfg_exp_t cm_q [$];

    // Bench-side model of the shadow and active tables.
    logic [MW-1:0] m_shadow, m_active;
    logic          m_dirty, m_den;
    logic [IW-1:0] m_didx;
    cfg_exp_t      got;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic cfg_rule_t slot_of(input logic [MW-1:0] m, input int i);
        return m[i*RW +: RW];
    endfunction

    function automatic cfg_rule_t mk_rule(input logic [31:0] idx, input logic [31:0] st, input logic [31:0] en);
        cfg_rule_t r;
        r.idx = idx; r.start_addr = st; r.end_addr = en;
        return r;
    endfunction

    // Model a write being presented this cycle; returns whether it is legal.
    function automatic logic model_write(input int sel, input cfg_rule_t r);
        logic ok;
        ok = (sel < NR) && (r.idx < NI);
        if (ok) begin
            m_shadow[sel*RW +: RW] = r;
            m_dirty = 1'b1;
        end
        return ok;
    endfunction

    task automatic model_commit(input logic en, input logic [IW-1:0] idx);
        cfg_exp_t e;
        m_den = en; m_didx = idx;
        e.map = m_shadow; e.en = en; e.idx = idx;
        cm_q.push_back(e);
    endtask

    // Pop the pending commit when the swap becomes visible and compare active outputs.
    task automatic expect_swap(input string tag);
        if (cm_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            got = cm_q.pop_front();
            m_active = got.map;
            m_dirty  = 1'b0;
            check({tag, "_map"}, map0, got.map);
            check({tag, "_den"}, den0, got.en);
            check({tag, "_didx"}, didx0, got.idx);
            check({tag, "_dirty"}, dirty0, 1'b0);
        end
    endtask

    // One write on dut0: drive, score err/dirty at the following cycle, release.
    task automatic write0(input int sel, input cfg_rule_t r, input logic exp_err);
        wr_exp_t e;
        logic ok;
        cfg0.wr_valid_i = 1'b1;
        cfg0.wr_sel_i   = RSW'(sel);
        cfg0.wr_rule_i  = r;
        check("wr_ready", cfg0.wr_ready_o, 1'b1);
        ok = model_write(sel, r);
        e.err = exp_err; e.dirty = m_dirty;
        wr_q.push_back(e);
        $display("[TB] write sel=%0d idx=%0d start=%0h end=%0h legal=%0b", sel, r.idx, r.start_addr, r.end_addr, ok);
        tick();
        cfg0.wr_valid_i = 1'b0;
        e = wr_q.pop_front();
        check("wr_err", cfg0.err_o, e.err);
        check("wr_dirty", dirty0, e.dirty);
    endtask

    task automatic reset_model();
        m_shadow = '0; m_active = '0; m_dirty = 1'b0; m_den = 1'b0; m_didx = '0;
        wr_q.delete(); cm_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cfg0.wr_valid_i = 0; cfg0.wr_sel_i = '0; cfg0.wr_rule_i = '0;
        cfg0.commit_valid_i = 0; cfg0.dflt_en_i = 0; cfg0.dflt_idx_i = '0;
        cfg1.wr_valid_i = 0; cfg1.wr_sel_i = '0; cfg1.wr_rule_i = '0;
        cfg1.commit_valid_i = 0; cfg1.dflt_en_i = 0; cfg1.dflt_idx_i = '0;
        reset_model();

        vecs[0] = '{sel: 2'd3, idx: 32'd0, st: 32'h0000, en: 32'h0100, exp_err: 1'b1};
        vecs[1] = '{sel: 2'd2, idx: 32'd4, st: 32'h0100, en: 32'h0200, exp_err: 1'b1};
        vecs[2] = '{sel: 2'd1, idx: 32'd2, st: 32'h1000, en: 32'h2000, exp_err: 1'b0};
        vecs[3] = '{sel: 2'd0, idx: 32'd1, st: 32'h0000, en: 32'h1000, exp_err: 1'b0};
        vecs[4] = '{sel: 2'd2, idx: 32'd3, st: 32'h2000, en: 32'h3000, exp_err: 1'b0};
        vecs[5] = '{sel: 2'd2, idx: 32'd0, st: 32'h3000, en: 32'h4000, exp_err: 1'b0};

        // Reset state, both while held and after release.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ongoing", ong0, 1'b1);
        check("rst_map", map0, '0);
        check("rst_wr_ready", cfg0.wr_ready_o, 1'b1);
        check("rst_commit_ready", cfg0.commit_ready_o, 1'b1);
        check("rst_dirty", dirty0, 1'b0);
        check("rst_err", cfg0.err_o, 1'b0);
        rst_n = 1'b1;
        tick();
        check("uncfg_ongoing", ong0, 1'b1);
        check("uncfg_ready", cfg0.wr_ready_o, 1'b1);

        // Table-driven writes while unconfigured; err must last exactly one cycle.
        for (int i = 0; i < 6; i++) begin
            write0(int'(vecs[i].sel), mk_rule(vecs[i].idx, vecs[i].st, vecs[i].en), vecs[i].exp_err);
            tick();
            check("err_one_cycle", cfg0.err_o, 1'b0);
            check("map_before_commit", map0, '0);
        end

        // Commit from UNCFG with busy low: ongoing t+1..t+2, map at t+2, low at t+3.
        cfg0.commit_valid_i = 1'b1; cfg0.dflt_en_i = 1'b1; cfg0.dflt_idx_i = 2'd2;
        check("c1_ready", cfg0.commit_ready_o, 1'b1);
        model_commit(1'b1, 2'd2);
        $display("[TB] commit dflt_en=1 dflt_idx=2 busy=0");
        tick();
        cfg0.commit_valid_i = 1'b0;
        check("c1_t1_ongoing", ong0, 1'b1);
        check("c1_t1_map_old", map0, m_active);
        check("c1_t1_wr_ready", cfg0.wr_ready_o, 1'b0);
        check("c1_t1_commit_ready", cfg0.commit_ready_o, 1'b0);
        tick();
        expect_swap("c1_t2");
        check("c1_t2_ongoing", ong0, 1'b1);
        check("c1_t2_slot1", slot_of(map0, 1), mk_rule(32'd2, 32'h1000, 32'h2000));
        tick();
        check("c1_t3_ongoing", ong0, 1'b0);
        check("c1_t3_ready", cfg0.wr_ready_o, 1'b1);

        // Rejected write while clean: dirty stays low, map untouched.
        write0(3, mk_rule(32'd1, 32'h7000, 32'h7100), 1'b1);
        check("rej_map", map0, m_active);

        // Commit stalled by busy for 5 cycles, swap on the first idle cycle.
        write0(0, mk_rule(32'd1, 32'h8000, 32'h9000), 1'b0);
        busy0 = 1'b1;
        cfg0.commit_valid_i = 1'b1; cfg0.dflt_en_i = 1'b0; cfg0.dflt_idx_i = 2'd3;
        model_commit(1'b0, 2'd3);
        $display("[TB] commit dflt_en=0 dflt_idx=3 busy=1");
        tick();
        cfg0.commit_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("busy_ongoing", ong0, 1'b1);
            check("busy_map_old", map0, m_active);
            check("busy_dirty", dirty0, 1'b1);
            tick();
        end
        busy0 = 1'b0;
        check("busy_release_map_old", map0, m_active);
        tick();
        expect_swap("busy");
        check("busy_swap_ongoing", ong0, 1'b1);
        tick();
        check("busy_end_ongoing", ong0, 1'b0);

        // Write and commit in the same cycle: the write is part of the commit.
        cfg0.wr_valid_i = 1'b1; cfg0.wr_sel_i = 2'd0;
        cfg0.wr_rule_i = mk_rule(32'd3, 32'h5000, 32'h6000);
        cfg0.commit_valid_i = 1'b1; cfg0.dflt_en_i = 1'b0; cfg0.dflt_idx_i = 2'd1;
        void'(model_write(0, mk_rule(32'd3, 32'h5000, 32'h6000)));
        model_commit(1'b0, 2'd1);
        $display("[TB] write+commit sel=0 idx=3 dflt_idx=1");
        tick();
        cfg0.wr_valid_i = 1'b0; cfg0.commit_valid_i = 1'b0;
        check("wc_t1_ongoing", ong0, 1'b1);
        tick();
        expect_swap("wc");
        check("wc_slot0_idx", slot_of(map0, 0).idx, 32'd3);
        tick();
        check("wc_t3_ongoing", ong0, 1'b0);

        // Reset asserted during SETTLE takes effect without a clock edge.
        write0(1, mk_rule(32'd1, 32'hA000, 32'hB000), 1'b0);
        cfg0.commit_valid_i = 1'b1; cfg0.dflt_en_i = 1'b1; cfg0.dflt_idx_i = 2'd3;
        model_commit(1'b1, 2'd3);
        $display("[TB] commit dflt_en=1 dflt_idx=3 then reset in settle");
        tick();
        cfg0.commit_valid_i = 1'b0;
        tick();
        expect_swap("pre_rst");
        rst_n = 1'b0;
        #1;
        reset_model();
        check("arst_ongoing", ong0, 1'b1);
        check("arst_map", map0, m_active);
        check("arst_den", den0, 1'b0);
        check("arst_didx", didx0, '0);
        check("arst_ready", cfg0.wr_ready_o, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ongoing", ong0, 1'b1);
        check("post_rst_map", map0, '0);

        // Zero settle cycles: ongoing only in t+1, low again at t+2.
        cfg1.wr_valid_i = 1'b1; cfg1.wr_sel_i = 2'd2;
        cfg1.wr_rule_i = mk_rule(32'd1, 32'hC000, 32'hD000);
        $display("[TB] s0 write sel=2 idx=1");
        tick();
        cfg1.wr_valid_i = 1'b0;
        check("s0_dirty", dirty1, 1'b1);
        cfg1.commit_valid_i = 1'b1; cfg1.dflt_en_i = 1'b1; cfg1.dflt_idx_i = 2'd1;
        $display("[TB] s0 commit dflt_en=1 dflt_idx=1");
        tick();
        cfg1.commit_valid_i = 1'b0;
        check("s0_t1_ongoing", ong1, 1'b1);
        check("s0_t1_map_old", map1, '0);
        tick();
        check("s0_t2_ongoing", ong1, 1'b0);
        check("s0_t2_slot2", slot_of(map1, 2), mk_rule(32'd1, 32'hC000, 32'hD000));
        check("s0_t2_den", den1, 1'b1);
        check("s0_t2_didx", didx1, 2'd1);
        check("s0_t2_dirty", dirty1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/addr_map_cfg_ctrl.md
Name: addr_map_cfg_ctrl

Overview:
- Runtime configuration controller for the dynamic address decoder (addr_decode_dync).
- Holds a shadow rule table written over a valid/ready port, plus an active table that drives the decoder.
- On commit, asserts config_ongoing_o and waits for downstream in-flight traffic to drain, then swaps shadow into active atomically.
- Holds config_ongoing_o for a settle window after the swap, so the decoder never sees a half-written map.

Parameters:
- NoRules, 4: number of rules in the table; must be >= 1.
- NoIndices, 4: number of decoder indices; a rule idx must be < NoIndices.
- addr_t, logic: address type.
- rule_t, logic: packed rule struct with fields idx, start_addr, end_addr (same as the decoder).
- SettleCycles, 1: cycles config_ongoing_o stays high after the swap; 0 is allowed.
- IdxWidth, cf_math_pkg::idx_width(NoIndices): derived; do not override.
- RuleSelWidth, cf_math_pkg::idx_width(NoRules): derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- wr_valid_i  in  1  rule write request.
- wr_ready_o  out  1  rule write accepted.
- wr_sel_i  in  RuleSelWidth  table slot to write.
- wr_rule_i  in  $bits(rule_t)  rule data.
- commit_valid_i  in  1  commit request.
- commit_ready_o  out  1  commit accepted.
- dflt_en_i  in  1  default-index enable, sampled at commit.
- dflt_idx_i  in  IdxWidth  default index, sampled at commit.
- busy_i  in  1  downstream transactions outstanding; the swap is blocked while high.
- addr_map_o  out  NoRules*$bits(rule_t)  active rule table.
- en_default_idx_o  out  1  active default enable.
- default_idx_o  out  IdxWidth  active default index.
- config_ongoing_o  out  1  map not valid; connect to the decoder's config_ongoing_i.
- dirty_o  out  1  shadow table differs from active (any write accepted since last swap).
- err_o  out  1  one-cycle pulse on a rejected write.

Behaviour:
- Reset (asynchronous, any state): all of the following take effect immediately.
  - Shadow and active tables = '0; en_default_idx_o=0; default_idx_o=0.
  - dirty_o=0; err_o=0; state=UNCFG; config_ongoing_o=1.
- FSM state meanings:
  - UNCFG: not yet configured; ongoing=1; writes and commits accepted.
  - IDLE: ongoing=0; writes and commits accepted.
  - DRAIN: ongoing=1; wr_ready_o=0; commit_ready_o=0.
  - SETTLE: ongoing=1; wr_ready_o=0; commit_ready_o=0; settle counter runs.
- Outputs are registered state decodes:
  - config_ongoing_o = (state != IDLE).
  - wr_ready_o = commit_ready_o = (state is UNCFG or IDLE).
- Write handshake (wr_valid_i & wr_ready_o):
  - If wr_sel_i < NoRules and wr_rule_i.idx < NoIndices: shadow[wr_sel_i] <= wr_rule_i; dirty_o <= 1.
  - Otherwise: shadow unchanged; err_o pulses high the next cycle.
  - Repeated writes to the same slot: last one wins.
- Commit handshake (commit_valid_i & commit_ready_o) at edge t:
  - Latch dflt_en_i and dflt_idx_i into shadow defaults.
  - state <= DRAIN, from UNCFG or IDLE.
  - A commit with dirty_o=0 is legal and performs a full cycle.
- Simultaneous write and commit in the same cycle: the write lands in shadow first and is included in the commit.
- DRAIN:
  - While busy_i=1, hold.
  - First cycle with busy_i=0: at that edge, active <= shadow (rules and defaults) and dirty_o <= 0.
  - Next state is SETTLE with counter = SettleCycles-1, or IDLE if SettleCycles==0.
- SETTLE: counter decrements each cycle; at 0, state <= IDLE.
- Commit timing with busy_i=0 and S = SettleCycles:
  - ongoing high in cycles t+1 .. t+1+S.
  - Active map visible from cycle t+2.
  - ongoing low from cycle t+2+S.
- addr_map_o, en_default_idx_o and default_idx_o change only at the swap edge, never while config_ongoing_o=0.
- busy_i may stay high indefinitely; the controller waits with no timeout.
- Reset mid-DRAIN or mid-SETTLE returns to UNCFG; the pending commit is discarded.
- Assertions (not synthesised): outputs stable while IDLE with no handshake; config_ongoing_o never low in DRAIN or SETTLE.

Decomposition:
- Add to addr_map_pkg: the FSM state enum (UNCFG, IDLE, DRAIN, SETTLE).
- The settle counter uses the existing common_cells counter, instantiated with width idx_width(SettleCycles+1).
- No further sub-module. The integrator instantiates addr_decode_dync next to this block, not inside it.

Test Plan:
- Reset release -> config_ongoing_o=1, addr_map_o='0, wr_ready_o=1, state UNCFG.
- Write sel=1 {idx=2,start=0x1000,end=0x2000}, commit at cycle 0, busy_i=0, S=1 -> ongoing high cycles 1-2, addr_map_o[1] updated cycle 2, ongoing low cycle 3, dirty_o=0.
- Commit with busy_i=1 for 5 cycles -> active map unchanged and ongoing high throughout; swap on the first busy_i=0 cycle.
- Write sel=NoRules, or rule idx=NoIndices -> handshake completes, err_o high one cycle, shadow and dirty_o unchanged.
- Write and commit in the same cycle (sel=0, idx=3) -> after the swap addr_map_o[0].idx=3.
- Reset asserted during SETTLE -> immediately UNCFG, active table '0, ongoing=1; S=0 variant: ongoing low at cycle t+2.
